pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the `en`/`clr` inputs of the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all of which are instances of the team's enable/clear register. It covers load-use interlock, branch flush, instruction-fetch wait and data-memory wait. A data-memory wait is guarded by a timeout, and the block keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `REG_W`, default 5: register-address width.
- `TIMEOUT`, default 64: maximum data-memory wait, in cycles, before the error state is entered.
- `CNT_W`, default 16: width of each statistics counter.

Ports:
- `clk` input, 1: system clock; all state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `id_rs`, `id_rt` input, REG_W: source registers of the instruction in ID.
- `id_uses_rt` input, 1: the ID instruction reads `rt`.
- `ex_memread` input, 1: the instruction in EX is a load.
- `ex_rt` input, REG_W: destination of that load.
- `branch_taken` input, 1: a branch resolved taken in EX this cycle.
- `imem_ready` input, 1: instruction memory has valid data this cycle.
- `dmem_req` input, 1: the instruction in MEM is accessing data memory.
- `dmem_ack` input, 1: the data-memory access completes this cycle.
- `pc_en` output, 1: PC register enable.
- `ifid_en`, `ifid_clr` output, 1 each: IF/ID register enable and clear.
- `idex_en`, `idex_clr` output, 1 each: ID/EX register enable and clear.
- `exmem_en`, `exmem_clr` output, 1 each: EX/MEM register enable and clear.
- `memwb_en`, `memwb_clr` output, 1 each: MEM/WB register enable and clear.
- `err` output, 1: sticky error flag, set on data-memory timeout.
- `stall_cnt` output, CNT_W: number of cycles with `pc_en`=0.
- `flush_cnt` output, CNT_W: number of branch flushes.

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: waiting for a data-memory access to complete.
  - ERR: dead-locked after a timeout.
- Control outputs are combinational from the state and the inputs. Default values are all `en`=1 and all `clr`=0.
- Behaviour in RUN, by priority (highest first):
  1. `dmem_req & !dmem_ack`:
     - Drive the freeze pattern: `pc_en`, `ifid_en`, `idex_en` and `exmem_en` = 0; `memwb_clr`=1.
     - Next state MEM_WAIT; the wait counter loads 1.
  2. `branch_taken`:
     - `ifid_clr`=1 and `idex_clr`=1.
     - `pc_en`=1, so the PC loads the branch target.
     - `flush_cnt` increments.
  3. Load-use hazard, defined as `ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`:
     - `pc_en`=0, `ifid_en`=0, `idex_clr`=1 (one bubble).
  4. `!imem_ready`:
     - `pc_en`=0, `ifid_clr`=1; later stages advance.
- MEM_WAIT:
  - The freeze pattern is held every cycle.
  - On `dmem_ack` the stages are released: all `en`=1 and `memwb_clr`=0 in that same cycle, and the next state is RUN.
  - `branch_taken` and hazard inputs are ignored while in this state.
  - If the counter reaches TIMEOUT with no ack: next state ERR, and `err` is set.
- ERR:
  - All `en`=0 and all `clr`=0 (full freeze).
  - The block leaves this state only on `rst`.
- Counters:
  - `stall_cnt` increments in every cycle where `pc_en`=0, including the ERR state.
  - Both counters saturate at all-ones and never wrap.
- Reset:
  - `rst`=1 at a rising edge forces state RUN, `err`=0, both counters 0 and the wait counter 0. This applies mid-wait and in ERR.
  - While `rst` is high the outputs take the RUN defaults (all `en`=1, all `clr`=0).

## Timing
- Control outputs have zero-cycle latency: they are valid in the same cycle as their inputs and are sampled by the pipeline registers at the next edge.
- Load-use inserts exactly 1 bubble. On the following cycle `ex_memread` belongs to the bubble, so the stall releases by construction.
- Branch flush squashes exactly 2 instructions, the ones in IF/ID and ID/EX.
- `dmem_req & dmem_ack` in the same RUN cycle causes no stall.
- A wait of N cycles (ack arrives N cycles after the req cycle) adds N stall cycles. The ack cycle itself is not a stall.
- Timeout:
  - With TIMEOUT=64, if the request cycle is cycle 0 and no ack arrives, the state enters ERR at the edge ending cycle 63.
  - `err` is visible from cycle 64 onward.
  - An ack arriving in cycle 63 takes precedence over the timeout.

## Structure
- A shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MEM_WAIT, ERR);
  - `REG_ZERO`;
  - the default TIMEOUT constant.
- One sub-module, `load_use_detect`: purely combinational register-compare logic, reused later by the forwarding unit.
- The FSM, wait counter and statistics counters stay in the top level.

## Test plan
- Load-use: `ex_memread`=1, `ex_rt`=3, `id_rs`=3.
  - Expect one cycle of `pc_en`=0, `ifid_en`=0, `idex_clr`=1.
  - `stall_cnt` goes 0→1.
  - Repeat with `ex_rt`=0: no stall.
- Branch + load-use in the same cycle:
  - Expect `ifid_clr`=`idex_clr`=1 and `pc_en`=1.
  - `flush_cnt`=1 and `stall_cnt` unchanged.
- Memory wait: `dmem_req` held, `dmem_ack` arriving after 3 cycles.
  - Expect 3 frozen cycles with `memwb_clr`=1, then release in the ack cycle.
  - `stall_cnt`=3; state returns to RUN.
- Timeout: `dmem_req`=1 with no ack (TIMEOUT=64).
  - `err`=1 from cycle 64 and every `en`=0.
  - Assert `rst` for 1 cycle: `err`=0, counters 0, all `en`=1.
- Saturation: CNT_W=4 with 20 consecutive `imem_ready`=0 cycles.
  - `stall_cnt` holds at 15.
  - `ifid_clr`=1 throughout.
- Reset mid-MEM_WAIT: assert `rst` at wait cycle 2.
  - Next cycle the state is RUN, counters are 0, and there is no spurious `err`.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_t;

  localparam int unsigned REG_ZERO        = 0;
  localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination feeds the ID instruction.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign hazard = ex_memread && (ex_rt != REG_W'(REG_ZERO)) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: drives en/clr of the PC and the four inter-stage registers,
// guards data-memory waits with a timeout, and keeps saturating stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic             exmem_clr,
  output logic             memwb_en,
  output logic             memwb_clr,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              dmem_stall;
  logic              flush;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use (
    .ex_memread(ex_memread),
    .ex_rt     (ex_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_uses_rt(id_uses_rt),
    .hazard    (load_use)
  );

  assign dmem_stall = dmem_req & ~dmem_ack;

  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    exmem_clr = 1'b0;
    memwb_en  = 1'b1;
    memwb_clr = 1'b0;
    flush     = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (dmem_stall) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
          end else if (branch_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            flush    = 1'b1;
          end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end else if (!imem_ready) begin
            pc_en    = 1'b0;
            ifid_clr = 1'b1;
          end
        end
        // The ack cycle releases immediately, so only non-ack cycles freeze.
        MEM_WAIT: begin
          if (!dmem_ack) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_clr = 1'b1;
          end
        end
        ERR: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))  flush_cnt <= flush_cnt + 1'b1;
      case (state)
        RUN: begin
          if (dmem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        // wait_cnt equals the number of cycles since the request cycle.
        MEM_WAIT: begin
          if (dmem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WAIT_W'(TIMEOUT - 1)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule
